// File: rtl/cic_integ_tdm.sv
// ---------------------------------------------------------------------------
// cic_integ_tdm
//   Time-division-multiplexed CIC integrator bank. One OW-bit accumulator per
//   channel, M channels interleaved on a single sample stream. Each accepted
//   sample is added (modulo 2^OW) to its channel's accumulator and the
//   updated value is emitted two cycles later, tagged with its channel.
//   Accumulators sit in an inferred RAM accessed read-modify-write.
//
//   Optional feature macro: CIC_INTEG_FLUSH_EN
//     defined   -> adds input `flush`; a flush in RUN drains the two-stage
//                  pipeline, re-clears every accumulator and resumes at chan 0.
//     undefined -> no `flush` port; accumulators are cleared only by reset.
//
// Ports
//   clk      in   rising-edge clock
//   resetn   in   synchronous active-low reset
//   flush    in   (CIC_INTEG_FLUSH_EN only) request drain + clear, honoured in RUN
//   s_valid  in   input sample valid
//   s_ready  out  block accepts a sample (transfer = s_valid & s_ready)
//   s_data   in   IW-bit two's-complement sample for the current channel
//   m_valid  out  updated accumulator valid (no backpressure)
//   m_data   out  updated accumulator value, holds when m_valid=0
//   m_chan   out  channel of m_data, holds when m_valid=0
//   busy     out  high whenever the block is not in RUN
// ---------------------------------------------------------------------------
module cic_integ_tdm #(
  parameter int M  = 256,
  parameter int IW = 5,
  parameter int OW = 48,
  localparam int AW = $clog2(M)
) (
  input  logic          clk,
  input  logic          resetn,
`ifdef CIC_INTEG_FLUSH_EN
  input  logic          flush,
`endif
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [IW-1:0] s_data,
  output logic          m_valid,
  output logic [OW-1:0] m_data,
  output logic [AW-1:0] m_chan,
  output logic          busy
);

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_RUN,
    ST_DRAIN
  } state_t;

  state_t        state;
  logic [AW-1:0] clr_addr;
  logic [AW-1:0] chan;
  logic          drain_cnt;

  // Stage 1 of the read-modify-write: accumulator read and extended sample.
  logic          v1;
  logic [AW-1:0] c1;
  logic [OW-1:0] ext_data;
  logic [OW-1:0] acc_rd;
  logic [OW-1:0] sum;

  logic [OW-1:0] acc_mem [M];
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [OW-1:0] mem_wdata;

  logic          xfer;
  logic          flush_req;

`ifdef CIC_INTEG_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  assign xfer = s_valid & s_ready;
  // Wrap-around modulo 2^OW is exactly what the integrator needs.
  assign sum  = acc_rd + ext_data;

  // CLEAR sweeps and pipeline write-backs never overlap: write-backs only
  // exist in RUN and during the two DRAIN cycles that precede a sweep.
  // Writes are suppressed under reset so in-flight samples are discarded.
  assign mem_we    = resetn & ((state == ST_CLEAR) | v1);
  assign mem_addr  = (state == ST_CLEAR) ? clr_addr : c1;
  assign mem_wdata = (state == ST_CLEAR) ? '0 : sum;

  // NOTE: the accumulator RAM and its datapath registers have no reset; a
  // reset would prevent RAM inference. Reset runs the CLEAR sweep instead,
  // and the datapath registers are only consumed when v1 qualifies them.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      acc_mem[mem_addr] <= mem_wdata;
    end
    if (xfer) begin
      // No forwarding needed: a channel recurs at least M >= 4 transfers
      // later, long after its previous write-back.
      acc_rd   <= acc_mem[chan];
      c1       <= chan;
      ext_data <= OW'($signed(s_data));
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values; later assignments in the block take priority.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= ST_CLEAR;
      clr_addr  <= '0;
      chan      <= '0;
      drain_cnt <= 1'b0;
      v1        <= 1'b0;
      s_ready   <= 1'b0;
      busy      <= 1'b1;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_chan    <= '0;
    end else begin
      v1      <= xfer;
      m_valid <= v1;
      if (v1) begin
        m_data <= sum;
        m_chan <= c1;
      end

      if (xfer) begin
        chan <= (chan == AW'(M - 1)) ? '0 : chan + 1'b1;
      end

      case (state)
        ST_CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == AW'(M - 1)) begin
            state   <= ST_RUN;
            s_ready <= 1'b1;
            busy    <= 1'b0;
            chan    <= '0;
          end
        end
        ST_RUN: begin
          // A sample offered alongside flush is still accepted.
          if (flush_req) begin
            state     <= ST_DRAIN;
            s_ready   <= 1'b0;
            busy      <= 1'b1;
            drain_cnt <= 1'b0;
          end
        end
        ST_DRAIN: begin
          // Two cycles let the last accepted samples write back first.
          drain_cnt <= 1'b1;
          if (drain_cnt) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
          end
        end
        default: begin
          state <= ST_CLEAR;
        end
      endcase
    end
  end

endmodule
